button_debounce: RTL and testbench

Conditions the raw mechanical push-button input before the rising-edge-detect/toggle stage that drives the light. Synchronises the asynchronous pin, rejects bounce and glitches shorter than a programmable stable window, and outputs a clean level plus single-cycle press/release pulses. The downstream toggle stage consumes `button_clean` (or `press_pulse` directly).

---
 rtl/button_debounce_pkg.sv | 14 +
 rtl/button_debounce_if.sv | 25 ++
 rtl/button_debounce_sync_2ff.sv | 22 ++
 rtl/button_debounce.sv | 95 +++++++++
 tb/tb_button_debounce.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/button_debounce_pkg.sv
// Shared definitions for the push-button conditioning path: FSM state
// encodings and the default stability window.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE_LOW  = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_IDLE_HIGH = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

endpackage

// File: rtl/button_debounce_if.sv
// Button bundle: raw pin towards the debouncer, clean level and strobes back.
interface button_debounce_if;

  logic button_in;
  logic button_clean;
  logic press_pulse;
  logic release_pulse;

  // Button source / consumer side
  modport master (
    output button_in,
    input  button_clean,
    input  press_pulse,
    input  release_pulse
  );

  // Debouncer side
  modport slave (
    input  button_in,
    output button_clean,
    output press_pulse,
    output release_pulse
  );

endinterface

// File: rtl/button_debounce_sync_2ff.sv
// 1-bit two-flop synchroniser with asynchronous active-high clear.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronises the raw pin, requires STABLE_CYCLES
// consecutive samples at a new level before accepting it, and emits a clean
// level plus one-cycle press/release strobes.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_W         = 4
) (
  input  logic           clk,
  input  logic           rst,
  button_debounce_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             clean_q;
  logic             press_q;
  logic             release_q;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.button_in),
    .q   (s2)
  );

  // Qualification FSM with registered level and strobes; the entry edge into
  // a WAIT state counts as the first stable sample, hence the STABLE_CYCLES-2
  // terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE_LOW;
      cnt       <= '0;
      clean_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state)
        ST_IDLE_LOW: begin
          if (s2) begin
            state <= ST_WAIT_HIGH;
            cnt   <= '0;
          end
        end
        ST_WAIT_HIGH: begin
          if (!s2) begin
            state <= ST_IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_IDLE_HIGH;
            cnt     <= '0;
            clean_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE_HIGH: begin
          if (!s2) begin
            state <= ST_WAIT_LOW;
            cnt   <= '0;
          end
        end
        ST_WAIT_LOW: begin
          if (s2) begin
            state <= ST_IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_IDLE_LOW;
            cnt       <= '0;
            clean_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.button_clean  = clean_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with a scoreboard of expected strobes.
module tb_button_debounce;

  localparam int LAT = 6;

  typedef struct {
    int cyc;
    bit press;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   n_press;
  int   n_rel;
  logic exp_clean;
  ev_t  q[$];

  button_debounce_if bif ();

  button_debounce #(
    .STABLE_CYCLES (4),
    .CNT_W         (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, expv);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic expect_ev(input bit press);
    ev_t e;
    e.cyc   = cyc + LAT;
    e.press = press;
    q.push_back(e);
  endtask

  // Per-cycle monitor: every edge is compared against the scoreboard
  initial begin
    ev_t e;
    logic exp_p, exp_r;
    cyc = 0;
    exp_clean = 1'b0;
    n_press = 0;
    n_rel = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        exp_clean = 1'b0;
        n_press = 0;
        n_rel = 0;
        chk("rst_clean", bif.button_clean, 1'b0);
        chk("rst_press", bif.press_pulse, 1'b0);
        chk("rst_release", bif.release_pulse, 1'b0);
      end else begin
        exp_p = 1'b0;
        exp_r = 1'b0;
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          exp_p = e.press;
          exp_r = !e.press;
          exp_clean = e.press;
        end
        chk("press_pulse", bif.press_pulse, exp_p);
        chk("release_pulse", bif.release_pulse, exp_r);
        chk("button_clean", bif.button_clean, exp_clean);
        if (bif.press_pulse) n_press++;
        if (bif.release_pulse) n_rel++;
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bif.button_in = 1'b1;

    // Reset with the button held high
    #2 rst = 1'b1;
    #1;
    chk("async_rst_clean", bif.button_clean, 1'b0);
    chk("async_rst_press", bif.press_pulse, 1'b0);
    chk("async_rst_release", bif.release_pulse, 1'b0);
    step(2);
    rst = 1'b0;
    expect_ev(1'b1);
    step(10);
    chk("reset_one_press", (n_press == 1), 1'b1);

    // Clean release then clean press
    bif.button_in = 1'b0;
    expect_ev(1'b0);
    step(10);
    bif.button_in = 1'b1;
    expect_ev(1'b1);
    step(10);
    bif.button_in = 1'b0;
    expect_ev(1'b0);
    step(10);

    // Glitch of 3 cycles: rejected
    bif.button_in = 1'b1;
    step(3);
    bif.button_in = 1'b0;
    step(10);

    // Pulse of exactly the minimum width: accepted
    bif.button_in = 1'b1;
    expect_ev(1'b1);
    step(4);
    bif.button_in = 1'b0;
    expect_ev(1'b0);
    step(12);

    // Press bounce: 1,0,1,0,1 then held high
    for (int i = 0; i < 5; i++) begin
      bif.button_in = (i % 2 == 0);
      if (i == 4) expect_ev(1'b1);
      step(1);
    end
    step(10);

    // Release bounce: 0,1,0,1,0 then held low
    for (int i = 0; i < 5; i++) begin
      bif.button_in = (i % 2 == 1);
      if (i == 4) expect_ev(1'b0);
      step(1);
    end
    step(10);
    chk("press_eq_release", (n_press == n_rel), 1'b1);

    // Reset in the middle of WAIT_HIGH, button kept high
    bif.button_in = 1'b1;
    step(4);
    rst = 1'b1;
    #1;
    chk("mid_rst_press", bif.press_pulse, 1'b0);
    chk("mid_rst_clean", bif.button_clean, 1'b0);
    step(2);
    rst = 1'b0;
    expect_ev(1'b1);
    step(10);
    chk("mid_rst_one_press", (n_press == n_rel + 1), 1'b1);
    bif.button_in = 1'b0;
    expect_ev(1'b0);
    step(10);
    chk("final_press_eq_release", (n_press == n_rel), 1'b1);
    chk("scoreboard_drained", (q.size() == 0), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
